wb_sample_fetch: RTL and testbench

//  Wishbone initiator (read-only) that fetches a block of 32-bit PCM words

---
 rtl/wb_sample_fetch.sv | 205 ++++++++++++++++++++
 tb/tb_wb_sample_fetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sample_fetch.sv
// wb_sample_fetch: read-only Wishbone burst initiator. It fetches a block of
// 32-bit PCM words from RAM into a small first-word-fall-through FIFO, which
// feeds the playback path through a valid/ready stream.
module wb_sample_fetch #(
    parameter int unsigned adr_width  = 16,
    parameter int unsigned burst_len  = 4,
    parameter int unsigned fifo_depth = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    // transfer control
    input  logic                          start_i,
    input  logic [adr_width-1:0]          base_adr_i,
    input  logic [15:0]                   len_i,
    output logic                          busy_o,
    output logic                          done_o,
    // Wishbone initiator
    output logic [adr_width-1:0]          wb_adr_o,
    input  logic [31:0]                   wb_dat_i,
    output logic                          wb_we_o,
    output logic                          wb_cyc_o,
    output logic                          wb_stb_o,
    output logic [2:0]                    wb_cti_o,
    input  logic                          wb_ack_i,
    // sample stream
    output logic [31:0]                   smp_dat_o,
    output logic                          smp_vld_o,
    input  logic                          smp_rdy_i,
    output logic [$clog2(fifo_depth):0]   fifo_lvl_o
);

    localparam int unsigned ptr_w  = $clog2(fifo_depth);
    localparam int unsigned lvl_w  = ptr_w + 1;
    localparam int unsigned beat_w = $clog2(burst_len) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_END = 3'b111;

    // control registers
    logic [1:0]            r_state;
    logic [adr_width-1:0]  r_adr;
    logic [15:0]           r_rem;
    logic [beat_w-1:0]     r_beat_cnt;
    logic [beat_w-1:0]     r_beats;
    logic [2:0]            r_cti;
    logic                  r_cyc;
    logic                  r_busy;
    logic                  r_done;

    // FIFO registers
    logic [31:0]           r_mem [fifo_depth];
    logic [ptr_w-1:0]      r_wr_ptr;
    logic [ptr_w-1:0]      r_rd_ptr;
    logic [lvl_w-1:0]      r_lvl;

    // next-state values
    logic [1:0]            w_state_nxt;
    logic [adr_width-1:0]  w_adr_nxt;
    logic [15:0]           w_rem_nxt;
    logic [beat_w-1:0]     w_beat_cnt_nxt;
    logic [beat_w-1:0]     w_beats_nxt;
    logic [2:0]            w_cti_nxt;
    logic [beat_w-1:0]     w_beats_arb;
    logic [beat_w-1:0]     w_beat_inc;
    logic [lvl_w-1:0]      w_free;
    logic                  w_push;
    logic                  w_pop;

    // free space and the size of the next burst as seen from ARB
    always_comb begin
        w_free      = lvl_w'(fifo_depth) - r_lvl;
        w_beats_arb = (r_rem >= 16'(burst_len)) ? beat_w'(burst_len) : beat_w'(r_rem);
        w_beat_inc  = beat_w'(r_beat_cnt + beat_w'(1));
        w_pop       = smp_rdy_i && (r_lvl != '0);
    end

    // next-state and datapath decode
    always_comb begin
        w_state_nxt    = r_state;
        w_adr_nxt      = r_adr;
        w_rem_nxt      = r_rem;
        w_beat_cnt_nxt = r_beat_cnt;
        w_beats_nxt    = r_beats;
        w_cti_nxt      = r_cti;
        w_push         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_adr_nxt   = base_adr_i;
                    w_rem_nxt   = len_i;
                    w_state_nxt = S_ARB;
                end
            end
            S_ARB: begin
                if (r_rem == 16'd0) begin
                    w_state_nxt = S_DONE;
                end else if (w_free >= lvl_w'(w_beats_arb)) begin
                    // the whole burst fits now, so the FIFO cannot overflow
                    w_beat_cnt_nxt = '0;
                    w_beats_nxt    = w_beats_arb;
                    w_cti_nxt      = (w_beats_arb == beat_w'(1)) ? CTI_END : CTI_INC;
                    w_state_nxt    = S_BURST;
                end
            end
            S_BURST: begin
                if (wb_ack_i) begin
                    w_push         = 1'b1;
                    w_adr_nxt      = r_adr + adr_width'(1);
                    w_rem_nxt      = r_rem - 16'd1;
                    w_beat_cnt_nxt = w_beat_inc;
                    if (r_cti == CTI_END) begin
                        w_cti_nxt   = 3'b000;
                        w_state_nxt = S_ARB;
                    end else begin
                        w_cti_nxt = (w_beat_inc == r_beats - beat_w'(1)) ? CTI_END : CTI_INC;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // transfer bookkeeping and registered bus/status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_adr      <= '0;
            r_rem      <= '0;
            r_beat_cnt <= '0;
            r_beats    <= '0;
            r_cti      <= '0;
            r_cyc      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_adr      <= w_adr_nxt;
            r_rem      <= w_rem_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_beats    <= w_beats_nxt;
            r_cti      <= w_cti_nxt;
            r_cyc      <= (w_state_nxt == S_BURST);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    // FIFO storage; contents need no reset since the level gates visibility
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wb_dat_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_lvl    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_lvl <= r_lvl + lvl_w'(1);
                2'b01:   r_lvl <= r_lvl - lvl_w'(1);
                default: r_lvl <= r_lvl;
            endcase
        end
    end

    // output mapping
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign wb_adr_o   = r_adr;
    assign wb_we_o    = 1'b0;
    assign wb_cyc_o   = r_cyc;
    assign wb_stb_o   = r_cyc;
    assign wb_cti_o   = r_cti;
    assign smp_vld_o  = (r_lvl != '0);
    assign smp_dat_o  = (r_lvl != '0) ? r_mem[r_rd_ptr] : 32'd0;
    assign fifo_lvl_o = r_lvl;

endmodule

// File: tb/tb_wb_sample_fetch.sv
// Self-checking bench for wb_sample_fetch with a behavioural RAM slave,
// randomized consumer back-pressure and a transfer-level reference model.
module tb_wb_sample_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_adr = '0;
    logic [15:0] len = '0;
    logic        busy, done;
    logic [15:0] adr;
    logic [31:0] wdat;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic        ack = 1'b0;
    logic [31:0] sdat;
    logic        svld;
    logic        srdy = 1'b0;
    logic [3:0]  lvl;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    wb_sample_fetch #(.adr_width(16), .burst_len(4), .fifo_depth(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_adr_i(base_adr), .len_i(len),
        .busy_o(busy), .done_o(done), .wb_adr_o(adr), .wb_dat_i(wdat), .wb_we_o(we),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_cti_o(cti), .wb_ack_i(ack),
        .smp_dat_o(sdat), .smp_vld_o(svld), .smp_rdy_i(srdy), .fifo_lvl_o(lvl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return 32'h0000_A000 + 32'(a);
    endfunction

    // RAM slave: ack one cycle after stb, held through incrementing beats
    int unsigned wait_n = 0;
    int unsigned wcnt = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 1'b0; wcnt <= 0;
        end else if (!cyc) begin
            ack <= 1'b0; wcnt <= 0;
        end else if (ack) begin
            ack <= (cti != 3'b111) && (wait_n == 0); wcnt <= 0;
        end else if (wcnt >= wait_n) begin
            ack <= 1'b1;
        end else begin
            wcnt <= wcnt + 1;
        end
    end
    assign wdat = ack ? ram_word(adr) : 32'hBAD0_0000;

    // consumer ready: 0 off, 1 on, 2 random
    int unsigned rdy_mode = 0;
    always @(posedge clk) begin
        #3;
        case (rdy_mode)
            0:       srdy = 1'b0;
            1:       srdy = 1'b1;
            default: srdy = 1'($urandom_range(0, 1));
        endcase
    end

    // transfer-level reference model
    logic [31:0] exp_q[$];
    logic [15:0] m_base = '0;
    int unsigned m_len = 0, m_beats = 0;
    int unsigned bi = 0, bl = 0;
    int unsigned done_cnt = 0, n_bursts = 0;
    bit          cyc_seen = 0, prev_wait = 0, gap_chk = 0, prev_cyc = 0;
    logic [15:0] prev_adr = '0;
    logic [2:0]  prev_cti = '0;

    // bus and stream monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            bi = 0; prev_wait = 0; gap_chk = 0; prev_cyc = 0;
        end else begin
            chk("stb_eq_cyc", 32'(stb), 32'(cyc));
            chk("we_zero", 32'(we), 32'd0);
            chk("lvl_le_depth", 32'(lvl <= 4'd8), 32'd1);
            if (cyc) cyc_seen = 1;
            if (cyc && !prev_cyc) n_bursts++;
            prev_cyc = cyc;
            if (gap_chk) begin
                chk("gap_after_burst", 32'(cyc), 32'd0);
                gap_chk = 0;
            end
            if (prev_wait && cyc) begin
                chk("wait_hold_adr", 32'(adr), 32'(prev_adr));
                chk("wait_hold_cti", 32'(cti), 32'(prev_cti));
            end
            prev_wait = cyc && !ack;
            prev_adr  = adr;
            prev_cti  = cti;
            if (cyc && ack) begin
                if (m_beats >= m_len) begin
                    chk("extra_beat", 32'(m_beats), 32'(m_len));
                end else begin
                    if (bi == 0) bl = (m_len - m_beats > 4) ? 4 : m_len - m_beats;
                    chk("beat_adr", 32'(adr), 32'(16'(m_base + 16'(m_beats))));
                    chk("beat_cti", 32'(cti), (bi == bl - 1) ? 32'd7 : 32'd2);
                    bi++;
                    m_beats++;
                    if (bi >= bl) begin bi = 0; gap_chk = 1; end
                end
            end
            if (svld && srdy) begin
                if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
                else chk("smp_dat", sdat, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                chk("done_all_words", 32'(m_beats), 32'(m_len));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_beats = 0; m_len = 0; bi = 0;
    endtask

    task automatic start_xfer(input logic [15:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_adr = b; len = n;
        m_base = b; m_len = 32'(n); m_beats = 0; bi = 0;
        for (int i = 0; i < int'(n); i++) exp_q.push_back(ram_word(16'(b + 16'(i))));
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("cyc_low_in_arb", 32'(cyc), 32'd0);
    endtask

    task automatic wait_done(input int limit);
        int unsigned c0 = done_cnt;
        bit got = 0;
        for (int i = 0; i < limit && !got; i++) begin
            @(posedge clk); #1;
            if (done_cnt != c0) got = 1;
        end
        chk("done_seen", 32'(got), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", 32'(done_cnt - c0), 32'd1);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        rdy_mode = 1;
        for (int i = 0; i < 200 && (svld || exp_q.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        chk("drain_model_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_lvl", 32'(lvl), 32'd0);
    endtask

    task automatic run_t1();
        rdy_mode = 1;
        start_xfer(16'h0010, 16'd4);
        @(posedge clk); #1;
        chk("t1_cyc_after_e1", 32'(cyc), 32'd1);
        wait_done(100);
        drain();
    endtask

    initial begin
        int unsigned b0, c0;
        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_cti", 32'(cti), 32'd0);
        chk("rst_adr", 32'(adr), 32'd0);
        chk("rst_vld", 32'(svld), 32'd0);
        chk("rst_lvl", 32'(lvl), 32'd0);
        chk("rst_dat", sdat, 32'd0);

        // T1 single 4-beat burst
        b0 = n_bursts;
        run_t1();
        chk("t1_one_burst", 32'(n_bursts - b0), 32'd1);

        // T2 back-pressure stall at full FIFO
        rdy_mode = 0;
        start_xfer(16'h0100, 16'd10);
        for (int i = 0; i < 100 && !(lvl == 4'd8 && !cyc); i++) begin
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("t2_stall_lvl", 32'(lvl), 32'd8);
        chk("t2_stall_cyc", 32'(cyc), 32'd0);
        chk("t2_stall_busy", 32'(busy), 32'd1);
        chk("t2_stall_words", 32'(m_beats), 32'd8);
        rdy_mode = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rdy_mode = 0;
        wait_done(100);
        chk("t2_lvl_after_done", 32'(lvl), 32'd8);
        drain();

        // T3 zero-length transfer
        cyc_seen = 0;
        c0 = done_cnt;
        start_xfer(16'h0055, 16'd0);
        @(posedge clk); #1;
        chk("t3_done_high", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("t3_done_low", 32'(done), 32'd0);
        chk("t3_busy_low", 32'(busy), 32'd0);
        chk("t3_done_count", 32'(done_cnt - c0), 32'd1);
        chk("t3_no_cycle", 32'(cyc_seen), 32'd0);

        // T4 burst across the address wrap
        b0 = n_bursts;
        rdy_mode = 1;
        start_xfer(16'hFFFE, 16'd4);
        wait_done(100);
        chk("t4_one_burst", 32'(n_bursts - b0), 32'd1);
        drain();

        // T5 reset in the middle of a burst
        rdy_mode = 1;
        start_xfer(16'h0010, 16'd8);
        for (int i = 0; i < 100 && m_beats < 2; i++) begin
            @(posedge clk); #1;
        end
        chk("t5_reached_beat2", 32'(m_beats >= 2), 32'd1);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t5_cyc", 32'(cyc), 32'd0);
        chk("t5_stb", 32'(stb), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_lvl", 32'(lvl), 32'd0);
        chk("t5_vld", 32'(svld), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_beats = 0; m_len = 0; bi = 0;
        run_t1();

        // T6 wait states, random back-pressure, start while busy
        wait_n = 2;
        rdy_mode = 2;
        start_xfer(16'h1234, 16'd7);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; base_adr = 16'h9999; len = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(500);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_second_xfer", 32'(busy), 32'd0);
        drain();

        // randomized transfers
        for (int k = 0; k < 8; k++) begin
            wait_n = $urandom_range(0, 2);
            rdy_mode = 2;
            start_xfer(16'($urandom), 16'($urandom_range(1, 20)));
            wait_done(2000);
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
